// File: rtl/sram_stage_sequencer.sv
// SRAM ownership sequencer: UART upload, then a chain of processing stages,
// then the SRAM goes back to the VGA reader. Also muxes the SRAM bus to the owner.
module sram_stage_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TIMER_W        = 26
) (
    input  logic                         CLOCK_50_I,
    input  logic                         resetn,
    input  logic                         UART_RX_I,
    input  logic [ADDR_W-1:0]            uart_address,
    input  logic [DATA_W-1:0]            uart_write_data,
    input  logic                         uart_we_n,
    output logic                         uart_initialize,
    output logic                         uart_enable,
    input  logic [ADDR_W-1:0]            vga_address,
    output logic                         vga_enable,
    input  logic [NUM_STAGES-1:0]        stage_enable_mask,
    input  logic                         rerun,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_finish,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data,
    input  logic [NUM_STAGES-1:0]        stage_we_n,
    output logic [ADDR_W-1:0]            sram_address,
    output logic [DATA_W-1:0]            sram_write_data,
    output logic                         sram_we_n,
    output logic [3:0]                   current_stage,
    output logic                         pipeline_done
);

    typedef enum logic [1:0] {S_IDLE, S_UART_RX, S_SELECT, S_RUN} state_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         LAST_STAGE = 4'(NUM_STAGES - 1);

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [3:0]              current_stage_q, current_stage_d;
    logic                    pipeline_done_q, pipeline_done_d;
    logic                    vga_enable_q, vga_enable_d;
    logic                    uart_initialize_q, uart_initialize_d;
    logic                    uart_enable_q, uart_enable_d;
    logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;

    logic [ADDR_W-1:0]       stage_addr_arr [NUM_STAGES];
    logic [DATA_W-1:0]       stage_data_arr [NUM_STAGES];
    logic [NUM_STAGES-1:0]   stage_sel_onehot;

    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_data;
    logic                    sel_we_n;
    logic                    sel_mask;
    logic                    sel_finish;
    logic                    last_stage;

    // Unpack the per-stage buses and decode the current stage index to one-hot
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_unpack
            assign stage_addr_arr[gi]   = stage_address[gi*ADDR_W +: ADDR_W];
            assign stage_data_arr[gi]   = stage_write_data[gi*DATA_W +: DATA_W];
            assign stage_sel_onehot[gi] = (current_stage_q == 4'(gi));
        end
    endgenerate

    assign last_stage = (current_stage_q == LAST_STAGE);

    // Pick the signals of the currently selected stage
    always_comb begin
        sel_addr   = '0;
        sel_data   = '0;
        sel_we_n   = 1'b1;
        sel_mask   = 1'b0;
        sel_finish = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_sel_onehot[i]) begin
                sel_addr   = stage_addr_arr[i];
                sel_data   = stage_data_arr[i];
                sel_we_n   = stage_we_n[i];
                sel_mask   = stage_enable_mask[i];
                sel_finish = stage_finish[i];
            end
        end
    end

    // Next-state and next-output computation for the ownership FSM
    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        current_stage_d   = current_stage_q;
        pipeline_done_d   = pipeline_done_q;
        stage_start_d     = stage_start_q;
        uart_initialize_d = 1'b0;
        uart_enable_d     = uart_initialize_q;

        case (state_q)
            S_IDLE: begin
                if (!UART_RX_I && !pipeline_done_q) begin
                    uart_initialize_d = 1'b1;
                    timer_d           = '0;
                    state_d           = S_UART_RX;
                end else if (rerun && pipeline_done_q) begin
                    pipeline_done_d = 1'b0;
                    current_stage_d = '0;
                    state_d         = S_SELECT;
                end
            end
            S_UART_RX: begin
                // Timeout wins over a write in the same cycle: the compare value always ends the upload
                if (timer_q == TIMER_LAST) begin
                    timer_d         = '0;
                    current_stage_d = '0;
                    state_d         = S_SELECT;
                end else if (!uart_we_n) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SELECT: begin
                if (sel_mask) begin
                    stage_start_d = stage_sel_onehot;
                    state_d       = S_RUN;
                end else if (last_stage) begin
                    pipeline_done_d = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    current_stage_d = current_stage_q + 4'd1;
                end
            end
            S_RUN: begin
                // Going through S_SELECT guarantees a low cycle on stage_start between stages
                if (sel_finish) begin
                    stage_start_d = '0;
                    if (last_stage) begin
                        pipeline_done_d = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        current_stage_d = current_stage_q + 4'd1;
                        state_d         = S_SELECT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        vga_enable_d = (state_d == S_IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            state_q           <= S_IDLE;
            timer_q           <= '0;
            current_stage_q   <= '0;
            pipeline_done_q   <= 1'b0;
            vga_enable_q      <= 1'b1;
            uart_initialize_q <= 1'b0;
            uart_enable_q     <= 1'b0;
            stage_start_q     <= '0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            current_stage_q   <= current_stage_d;
            pipeline_done_q   <= pipeline_done_d;
            vga_enable_q      <= vga_enable_d;
            uart_initialize_q <= uart_initialize_d;
            uart_enable_q     <= uart_enable_d;
            stage_start_q     <= stage_start_d;
        end
    end

    // SRAM bus follows whoever owns the memory in the current state
    always_comb begin
        sram_address    = vga_address;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
        case (state_q)
            S_UART_RX: begin
                sram_address    = uart_address;
                sram_write_data = uart_write_data;
                sram_we_n       = uart_we_n;
            end
            S_SELECT: begin
                sram_address    = sel_addr;
                sram_write_data = sel_data;
                sram_we_n       = 1'b1;
            end
            S_RUN: begin
                sram_address    = sel_addr;
                sram_write_data = sel_data;
                sram_we_n       = sel_we_n;
            end
            default: ;
        endcase
    end

    assign uart_initialize = uart_initialize_q;
    assign uart_enable     = uart_enable_q;
    assign vga_enable      = vga_enable_q;
    assign stage_start     = stage_start_q;
    assign current_stage   = current_stage_q;
    assign pipeline_done   = pipeline_done_q;

endmodule

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
- Top-level SRAM ownership sequencer and bus multiplexer for the decoder datapath.
- Detects a UART upload, hands the SRAM to the UART receiver, and ends the upload on a line-idle timeout.
- Then runs NUM_STAGES processing stages in order using start/finish handshakes, skipping masked stages.
- Returns the SRAM to the VGA reader when all stages are done. Supports re-running the stage chain without a new upload.

Parameters:
- NUM_STAGES, 3, number of processing stages (1..15).
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- TIMEOUT_CYCLES, 50000000, idle cycles that end an upload (1 s at 50 MHz).
- TIMER_W, 26, timer width; must hold TIMEOUT_CYCLES-1.

Ports:
- CLOCK_50_I  in  1  system clock.
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of CLOCK_50_I.
- UART_RX_I  in  1  raw UART line, used for start-bit detection.
- uart_address  in  ADDR_W  UART interface SRAM address.
- uart_write_data  in  DATA_W  UART interface write data.
- uart_we_n  in  1  UART interface write strobe, active low.
- uart_initialize  out  1  one-cycle pulse to the UART interface.
- uart_enable  out  1  one-cycle pulse, the cycle after uart_initialize.
- vga_address  in  ADDR_W  VGA reader address.
- vga_enable  out  1  VGA reader enable.
- stage_enable_mask  in  NUM_STAGES  bit i = 1 means stage i runs.
- rerun  in  1  request to re-run the stage chain; honoured only when pipeline_done = 1.
- stage_start  out  NUM_STAGES  one-hot level start, one bit per stage.
- stage_finish  in  NUM_STAGES  per-stage finish, level or pulse.
- stage_address  in  NUM_STAGES*ADDR_W  packed; stage i occupies bits [i*ADDR_W +: ADDR_W].
- stage_write_data  in  NUM_STAGES*DATA_W  packed in the same way.
- stage_we_n  in  NUM_STAGES  per-stage write strobe, active low.
- sram_address  out  ADDR_W  to the SRAM controller.
- sram_write_data  out  DATA_W  to the SRAM controller.
- sram_we_n  out  1  to the SRAM controller.
- current_stage  out  4  index of the stage being selected or run.
- pipeline_done  out  1  sticky flag: the stage chain has completed.

Behaviour:
- States: S_IDLE, S_UART_RX, S_SELECT, S_RUN.
- Reset (resetn = 0 at a clock edge): state S_IDLE; all registered outputs take their reset values on that edge.
  - vga_enable = 1; timer = 0; current_stage = 0; pipeline_done = 0.
  - uart_initialize = 0; uart_enable = 0; stage_start = 0.
  - Reset mid-upload or mid-stage takes the same action; stage_start drops on that edge.
- S_IDLE:
  - vga_enable = 1.
  - If UART_RX_I = 0 and pipeline_done = 0: uart_initialize <= 1, timer <= 0, vga_enable <= 0, go to S_UART_RX.
  - Else if rerun = 1 and pipeline_done = 1: pipeline_done <= 0, current_stage <= 0, go to S_SELECT.
  - UART_RX_I low while pipeline_done = 1 is ignored.
- S_UART_RX:
  - uart_initialize clears after 1 cycle; uart_enable = 1 for exactly the cycle after uart_initialize.
  - timer increments every cycle; it is cleared in any cycle where uart_we_n = 0.
  - When timer = TIMEOUT_CYCLES-1: timer <= 0, current_stage <= 0, go to S_SELECT.
- S_SELECT (one cycle per evaluation; stage_start = 0 throughout):
  - If stage_enable_mask[current_stage] = 1: stage_start[current_stage] <= 1, go to S_RUN.
  - Else if current_stage = NUM_STAGES-1: pipeline_done <= 1, go to S_IDLE.
  - Else: current_stage <= current_stage + 1, stay in S_SELECT.
- S_RUN:
  - stage_start stays one-hot on current_stage.
  - stage_finish bits of other stages are ignored.
  - On stage_finish[current_stage] = 1: stage_start <= 0.
    - If current_stage = NUM_STAGES-1: pipeline_done <= 1, go to S_IDLE.
    - Else: current_stage <= current_stage + 1, go to S_SELECT.
  - Every started stage therefore sees stage_start low for at least 1 cycle before any later start.
- SRAM mux (combinational from state):
  - S_RUN: sram_* follow stage current_stage's address, write data and we_n.
  - S_SELECT: stage address selected; sram_we_n forced to 1.
  - S_UART_RX: sram_* follow the uart_* inputs.
  - S_IDLE: vga_address, write data 0, sram_we_n = 1.
- stage_enable_mask is sampled live in S_SELECT. An all-zero mask reaches done after NUM_STAGES S_SELECT cycles.
- The timer saturates at no value: reaching the compare value always causes the transition.

Test Plan:
- Reset, then hold UART_RX_I = 1 for 100 cycles -> state S_IDLE, vga_enable = 1, sram_address = vga_address, sram_we_n = 1.
- UART_RX_I low for 1 cycle -> uart_initialize high 1 cycle, then uart_enable high 1 cycle; a uart_we_n = 0 pulse at timer 40 clears the timer. With TIMEOUT_CYCLES = 64, S_SELECT is entered 64 cycles after the last write.
- NUM_STAGES = 3, mask = 3'b111, each finish 10 cycles after its start -> stage_start sequence 001, 010, 100 with a 1-cycle zero gap between starts; pipeline_done = 1; S_IDLE.
- mask = 3'b101 -> stage 1 never started; current_stage goes 0, 1 (one S_SELECT cycle), 2; done afterwards.
- During S_RUN on stage 0, assert stage_finish[2] -> ignored; then drive stage_we_n[0] = 0 -> sram_we_n = 0. In the S_SELECT cycle, sram_we_n = 1 even with stage_we_n = 0.
- pipeline_done = 1, UART_RX_I low -> ignored. Then rerun = 1 -> pipeline_done clears and stage 0 restarts. Drive resetn = 0 mid-run -> stage_start = 0 and state S_IDLE on the next edge.
